// File: rtl/mxv_tx_frame_sequencer.sv
// Transmit-side frame sequencer: drains MxV result words from the result FIFO and drives the
// byte-serial UART TX with one SOF/length/command/payload/EOF frame per start request.
module mxv_tx_frame_sequencer #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned LEN_W    = 8,
  parameter logic [7:0]  SOF_BYTE = 8'hFE,
  parameter logic [7:0]  CMD_BYTE = 8'h04,
  parameter logic [7:0]  EOF_BYTE = 8'hEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  matrix_length,
  input  logic              res_empty,
  output logic              res_pop,
  input  logic [DATA_W-1:0] res_data,
  input  logic              tx_busy,
  input  logic              tx_done,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned     NumBytes = DATA_W / 8;
  localparam int unsigned     IdxW     = (NumBytes > 1) ? $clog2(NumBytes) : 1;
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(NumBytes - 1);

  typedef enum logic [3:0] {
    StIdle, StSof, StLen, StCmd, StPop, StCapt, StByte, StEof, StFin
  } state_e;

  state_e             state_q, state_d, send_next;
  // Byte-send states: 0 = launch, 1 = wait for tx_done. CAPT: 0 = pop in flight, 1 = data valid.
  logic               phase_q, phase_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   word_cnt_q, word_cnt_d;
  logic [DATA_W-1:0]  word_q, word_d;
  logic [IdxW-1:0]    byte_idx_q, byte_idx_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic               res_pop_q, res_pop_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;
  logic [7:0]         send_byte;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      phase_q      <= 1'b0;
      len_q        <= '0;
      word_cnt_q   <= '0;
      word_q       <= '0;
      byte_idx_q   <= '0;
      tx_data_q    <= 8'h00;
      tx_start_q   <= 1'b0;
      res_pop_q    <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      len_q        <= len_d;
      word_cnt_q   <= word_cnt_d;
      word_q       <= word_d;
      byte_idx_q   <= byte_idx_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
      res_pop_q    <= res_pop_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Byte to send and successor state for each byte-send state.
  always_comb begin
    send_byte = SOF_BYTE;
    send_next = StLen;
    unique case (state_q)
      StSof: begin
        send_byte = SOF_BYTE;
        send_next = StLen;
      end
      StLen: begin
        send_byte = len_q[7:0];
        send_next = StCmd;
      end
      StCmd: begin
        send_byte = CMD_BYTE;
        send_next = (len_q != '0) ? StPop : StEof;
      end
      StByte: begin
        send_byte = word_q[{byte_idx_q, 3'b000} +: 8];
        if (byte_idx_q != '0) begin
          send_next = StByte;
        end else if ((word_cnt_q + LEN_W'(1)) < len_q) begin
          send_next = StPop;
        end else begin
          send_next = StEof;
        end
      end
      StEof: begin
        send_byte = EOF_BYTE;
        send_next = StFin;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    len_d        = len_q;
    word_cnt_d   = word_cnt_q;
    word_d       = word_q;
    byte_idx_d   = byte_idx_q;
    tx_data_d    = tx_data_q;
    busy_d       = busy_q;
    tx_start_d   = 1'b0;
    res_pop_d    = 1'b0;
    frame_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          len_d      = matrix_length;
          word_cnt_d = '0;
          busy_d     = 1'b1;
          phase_d    = 1'b0;
          state_d    = StSof;
        end
      end
      StPop: begin
        if (!res_empty) begin
          res_pop_d = 1'b1;
          phase_d   = 1'b0;
          state_d   = StCapt;
        end
      end
      StCapt: begin
        // The FIFO sees the registered pop one cycle late, so data lands a cycle after that.
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          word_d     = res_data;
          byte_idx_d = LastIdx;
          phase_d    = 1'b0;
          state_d    = StByte;
        end
      end
      StFin: state_d = StIdle;
      default: begin
        if (!phase_q) begin
          tx_data_d = send_byte;
          if (!tx_busy) begin
            tx_start_d = 1'b1;
            phase_d    = 1'b1;
          end
        end else if (tx_done) begin
          phase_d = 1'b0;
          state_d = send_next;
          if (state_q == StByte) begin
            if (byte_idx_q != '0) begin
              byte_idx_d = byte_idx_q - IdxW'(1);
            end else begin
              word_cnt_d = word_cnt_q + LEN_W'(1);
            end
          end
          if (state_q == StEof) begin
            frame_done_d = 1'b1;
            busy_d       = 1'b0;
          end
        end
      end
    endcase
  end

  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign res_pop    = res_pop_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_mxv_tx_frame_sequencer.sv
// Self-checking bench for mxv_tx_frame_sequencer: UART and result-FIFO models plus a frame-level
// reference that builds the expected byte stream from the length and the FIFO words.
module tb_mxv_tx_frame_sequencer;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned LEN_W  = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [LEN_W-1:0]  matrix_length;
  logic              res_empty = 1'b1;
  logic              res_pop;
  logic [DATA_W-1:0] res_data = '0;
  logic              tx_busy;
  logic              tx_done;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              busy;
  logic              frame_done;

  mxv_tx_frame_sequencer #(
    .DATA_W(DATA_W),
    .LEN_W (LEN_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .matrix_length(matrix_length),
    .res_empty    (res_empty),
    .res_pop      (res_pop),
    .res_data     (res_data),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  int unsigned       cyc = 0;
  int unsigned       byte_cyc = 10;
  int unsigned       uart_cnt = 0;
  logic              uart_busy = 1'b0;
  logic              uart_done = 1'b0;
  logic              force_busy = 1'b0;
  logic              glitch_done = 1'b0;
  logic [7:0]        uart_byte = 8'h00;
  logic [7:0]        obs[$];
  logic [DATA_W-1:0] fifo[$];
  logic [DATA_W-1:0] words[$];
  logic              pop_pending = 1'b0;
  logic [DATA_W-1:0] pop_word = '0;
  int unsigned       n_start = 0, n_pop = 0, n_fdone = 0;
  int unsigned       first_start_cyc = 0, start_cyc = 0, rel_cyc = 0;
  int unsigned       base_start = 0, base_pop = 0, base_fd = 0;

  assign tx_busy = uart_busy | force_busy;
  assign tx_done = uart_done | glitch_done;

  always @(posedge clk) cyc++;

  // UART and FIFO models: sample DUT outputs on the falling edge, update inputs there too.
  always @(negedge clk) begin
    if (!reset) begin
      uart_busy   = 1'b0;
      uart_done   = 1'b0;
      uart_cnt    = 0;
      pop_pending = 1'b0;
      res_data    = '0;
    end else begin
      uart_done = 1'b0;
      if (tx_start) begin
        check_eq("start_while_busy", tx_busy, 0);
        if (obs.size() == 0) first_start_cyc = cyc;
        obs.push_back(tx_data);
        n_start++;
        uart_byte = tx_data;
        uart_busy = 1'b1;
        uart_cnt  = byte_cyc;
      end else if (uart_busy) begin
        check_eq("tx_data_hold", tx_data, uart_byte);
        uart_cnt--;
        if (uart_cnt == 0) begin
          uart_busy = 1'b0;
          uart_done = 1'b1;
        end
      end
      if (pop_pending) begin
        res_data    = pop_word;
        pop_pending = 1'b0;
      end
      if (res_pop) begin
        n_pop++;
        check_eq("pop_when_empty", fifo.size() == 0, 0);
        pop_word    = (fifo.size() > 0) ? fifo.pop_front() : '0;
        pop_pending = 1'b1;
        res_data    = DATA_W'($urandom());
      end
      if (frame_done) n_fdone++;
    end
    res_empty = (fifo.size() == 0);
  end

  task automatic load_words();
    foreach (words[k]) fifo.push_back(words[k]);
  endtask

  task automatic launch(input int unsigned len);
    @(negedge clk);
    obs.delete();
    start_cyc     = cyc;
    base_start    = n_start;
    base_pop      = n_pop;
    base_fd       = n_fdone;
    matrix_length = LEN_W'(len);
    start         = 1'b1;
    @(negedge clk);
    start         = 1'b0;
    matrix_length = LEN_W'($urandom());
    check_eq("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input int unsigned budget, input bit poke_fin);
    int unsigned n;
    n = 0;
    while (frame_done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("frame_done_seen", n < budget, 1);
    if (poke_fin) begin
      start         = 1'b1;
      matrix_length = LEN_W'(3);
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic wait_bytes(input int unsigned nb);
    int unsigned n;
    n = 0;
    while (obs.size() < nb && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check_eq("byte_wait", n < 1000, 1);
  endtask

  // Reference frame: SOF, length, command, each word MSB byte first, EOF.
  task automatic check_frame(input int unsigned len);
    logic [7:0]        exp[$];
    logic [DATA_W-1:0] w;
    logic [31:0]       got;
    @(negedge clk);
    exp.push_back(8'hFE);
    exp.push_back(8'(len));
    exp.push_back(8'h04);
    foreach (words[i]) begin
      w = words[i];
      for (int b = DATA_W / 8 - 1; b >= 0; b--) exp.push_back(8'((w >> (8 * b)) & 'hFF));
    end
    exp.push_back(8'hEF);
    check_eq("frame_byte_count", obs.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < obs.size()) ? 32'(obs[i]) : 32'hFFFF_FFFF;
      check_eq($sformatf("byte[%0d]", i), got, 32'(exp[i]));
    end
    check_eq("pop_count", n_pop - base_pop, len);
    check_eq("frame_done_count", n_fdone - base_fd, 1);
    check_eq("frame_done_width", frame_done, 0);
    check_eq("busy_after_frame", busy, 0);
  endtask

  int unsigned rlen;
  int unsigned snap_start, snap_pop;

  initial begin
    reset         = 1'b0;
    start         = 1'b0;
    matrix_length = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_tx_start", tx_start, 0);
    check_eq("rst_tx_data", tx_data, 0);
    check_eq("rst_res_pop", res_pop, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_frame_done", frame_done, 0);
    reset = 1'b1;

    // Four-word frame with 10-cycle UART bytes.
    words = '{16'h1234, 16'h0056, 16'hABCD, 16'hFFFF};
    load_words();
    launch(4);
    wait_done(2000, 1'b0);
    check_frame(4);
    check_eq("start_latency", first_start_cyc - start_cyc, 2);

    // Empty payload.
    words.delete();
    launch(0);
    wait_done(2000, 1'b0);
    check_frame(0);

    // FIFO empty after CMD: stall with no pops or bytes; a stray tx_done must be ignored.
    words = '{16'h00A5};
    launch(1);
    wait_bytes(3);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      glitch_done = (i == 30);
    end
    glitch_done = 1'b0;
    check_eq("stall_no_pop", n_pop - base_pop, 0);
    check_eq("stall_no_start", n_start - base_start, 3);
    load_words();
    wait_done(2000, 1'b0);
    check_frame(1);

    // UART busy at SOF launch: first tx_start only after busy drops.
    words = '{16'h5AC3};
    load_words();
    force_busy = 1'b1;
    launch(1);
    repeat (19) @(negedge clk);
    check_eq("busy_hold_no_start", n_start - base_start, 0);
    force_busy = 1'b0;
    rel_cyc    = cyc;
    wait_done(2000, 1'b0);
    check_frame(1);
    check_eq("start_after_release", first_start_cyc - rel_cyc, 1);

    // Reset mid-frame, then a fresh frame.
    words = '{16'h1111, 16'h2222, 16'h3333};
    load_words();
    launch(3);
    wait_bytes(5);
    #2 reset = 1'b0;
    #1;
    check_eq("midrst_tx_start", tx_start, 0);
    check_eq("midrst_tx_data", tx_data, 0);
    check_eq("midrst_res_pop", res_pop, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_frame_done", frame_done, 0);
    snap_start = n_start;
    snap_pop   = n_pop;
    fifo.delete();
    repeat (10) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("after_rst_no_start", n_start - snap_start, 0);
    check_eq("after_rst_no_pop", n_pop - snap_pop, 0);
    words = '{16'hBEEF, 16'h0102};
    load_words();
    launch(2);
    wait_done(2000, 1'b0);
    check_frame(2);

    // Start while busy and in the FIN cycle: both ignored.
    words = '{16'hC0DE, 16'h7E57};
    load_words();
    launch(2);
    wait_bytes(3);
    @(negedge clk);
    start         = 1'b1;
    matrix_length = LEN_W'(7);
    @(negedge clk);
    start = 1'b0;
    wait_done(2000, 1'b1);
    check_frame(2);
    repeat (30) @(negedge clk);
    check_eq("no_extra_bytes", n_start - base_start, 8);
    check_eq("no_extra_frame_done", n_fdone - base_fd, 1);
    check_eq("idle_busy_low", busy, 0);

    // Randomised frames, word values and UART byte durations.
    for (int f = 0; f < 10; f++) begin
      rlen     = $urandom_range(0, 6);
      byte_cyc = $urandom_range(1, 8);
      words.delete();
      for (int k = 0; k < rlen; k++) words.push_back(DATA_W'($urandom()));
      load_words();
      repeat ($urandom_range(0, 5)) @(negedge clk);
      launch(rlen);
      wait_done(3000, 1'b0);
      check_frame(rlen);
      check_eq("rand_start_latency", first_start_cyc - start_cyc, 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule
